// File: rtl/axisdma_sink.sv
// axisdma_sink: AXI-stream to memory writer.
// Each accepted stream beat becomes one word write on a valid/ready memory
// port. Writes go to consecutive byte addresses starting at a base address.
// The memory port is framed into bursts of burst_len beats.
// Optional build macro AXISDMA_WRAP_EN: when defined, filling the buffer
// without seeing tlast wraps back to the base address (ring buffer). When not
// defined, the overflow is flagged and the rest of the capture is discarded.
module axisdma_sink #(
    parameter int dataw     = 32,
    parameter int saddr_w   = 24,
    parameter int addr_w    = 32,
    parameter int burst_len = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [dataw-1:0]   slave_tdata,
    input  logic               slave_tvalid,
    output logic               slave_tready,
    input  logic               slave_tlast,
    input  logic               start,
    input  logic               abort,
    input  logic [addr_w-1:0]  base_addr,
    input  logic [saddr_w-1:0] buffer_size,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic               aborted,
    output logic [saddr_w-1:0] words_written,
    output logic [addr_w-1:0]  mem_addr,
    output logic [dataw-1:0]   mem_wdata,
    output logic               mem_wvalid,
    input  logic               mem_wready,
    output logic               mem_wlast
);

    localparam int BYTES = dataw / 8;
    localparam int BL_W  = $clog2(burst_len);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DISCARD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [addr_w-1:0]  base_q;
    logic [saddr_w-1:0] size_q;
    logic [saddr_w-1:0] index_q;
    logic [saddr_w-1:0] index_d;
    logic [saddr_w-1:0] words_q;
    logic               error_q;
    logic               aborted_q;
    logic               done_q;
    logic               wvalid_q;
    logic               wlast_q;
    logic [addr_w-1:0]  waddr_q;
    logic [dataw-1:0]   wdata_q;

    logic               out_free;
    logic               beat_acc;
    logic               mem_hs;
    logic               burst_end;
    logic [addr_w-1:0]  beat_addr;
    logic [BL_W-1:0]    phase;

    // Output register can take a new beat when it is empty or emptying now.
    assign out_free  = !wvalid_q || mem_wready;
    assign mem_hs    = wvalid_q && mem_wready;
    assign beat_acc  = slave_tvalid && slave_tready;
    assign index_d   = index_q + saddr_w'(1);
    assign phase     = index_q[BL_W-1:0];
    assign burst_end = &phase;
    assign beat_addr = base_q + addr_w'(index_q) * addr_w'(BYTES);

    // Stream ready: throttled by the output register in RUN, always open in
    // DISCARD so the upstream FIFO is drained rather than stalled.
    always_comb begin
        slave_tready = 1'b0;
        case (state_q)
            S_RUN:     slave_tready = out_free && (index_q < size_q);
            S_DISCARD: slave_tready = 1'b1;
            default:   slave_tready = 1'b0;
        endcase
    end

    // Transfer FSM together with the memory output register and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            size_q    <= '0;
            index_q   <= '0;
            words_q   <= '0;
            error_q   <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
            wvalid_q  <= 1'b0;
            wlast_q   <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            done_q <= 1'b0;

            // Memory handshake retires the pending beat and counts it.
            if (mem_hs) begin
                wvalid_q <= 1'b0;
                if (words_q != '1) begin
                    words_q <= words_q + saddr_w'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q    <= base_addr;
                        size_q    <= buffer_size;
                        index_q   <= '0;
                        words_q   <= '0;
                        error_q   <= 1'b0;
                        aborted_q <= 1'b0;
                        if (buffer_size == '0) begin
                            // Zero size passes through DRAIN with an empty
                            // output register, giving done two cycles later.
                            error_q <= 1'b1;
                            state_q <= S_DRAIN;
                        end else begin
                            state_q <= S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    if (beat_acc) begin
                        wvalid_q <= 1'b1;
                        wdata_q  <= slave_tdata;
                        waddr_q  <= beat_addr;
                        wlast_q  <= burst_end || slave_tlast;
                        index_q  <= index_d;
                    end
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end else if (beat_acc && slave_tlast) begin
                        state_q <= S_DRAIN;
                    end else if (beat_acc && (index_d == size_q)) begin
`ifdef AXISDMA_WRAP_EN
                        // Ring mode: restart at the base and a fresh burst.
                        index_q <= '0;
`else
                        error_q <= 1'b1;
                        state_q <= S_DISCARD;
`endif
                    end
                end

                S_DISCARD: begin
                    if (abort) begin
                        aborted_q <= 1'b1;
                        state_q   <= S_DRAIN;
                    end else if (slave_tvalid && slave_tlast) begin
                        state_q <= S_DRAIN;
                    end
                end

                S_DRAIN: begin
                    if (!wvalid_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign error         = error_q;
    assign aborted       = aborted_q;
    assign words_written = words_q;
    assign mem_addr      = waddr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wvalid    = wvalid_q;
    assign mem_wlast     = wlast_q;

endmodule

// File: tb/tb_axisdma_sink.sv
// Testbench for axisdma_sink: randomized stream and memory-ready stimulus
// checked against a list of expected writes derived from base, size, beat
// count, burst length and the tlast/abort position.
module tb_axisdma_sink;

    localparam int BL = 16;
`ifdef AXISDMA_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] slave_tdata;
    logic        slave_tvalid;
    logic        slave_tready;
    logic        slave_tlast;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [23:0] buffer_size;
    logic        busy;
    logic        done;
    logic        error;
    logic        aborted;
    logic [23:0] words_written;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wvalid;
    logic        mem_wready;
    logic        mem_wlast;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    axisdma_sink #(
        .dataw(32), .saddr_w(24), .addr_w(32), .burst_len(BL)
    ) dut (
        .clk(clk), .reset(reset),
        .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid),
        .slave_tready(slave_tready), .slave_tlast(slave_tlast),
        .start(start), .abort(abort),
        .base_addr(base_addr), .buffer_size(buffer_size),
        .busy(busy), .done(done), .error(error), .aborted(aborted),
        .words_written(words_written),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wvalid(mem_wvalid),
        .mem_wready(mem_wready), .mem_wlast(mem_wlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One complete transfer: builds the expected write list, drives the stream
    // and memory ready, and compares every write, the hold rule, done timing
    // and the final status.
    task automatic run_xfer(input string name, input logic [31:0] base,
                            input int size, input int nbeats, input int rmode,
                            input int abort_at, input bit chk_stall,
                            input bit poke_start);
        logic [31:0] data[];
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        logic        el[$];
        logic [31:0] xa, xd, pa, pd;
        logic        xl, pl;
        int nexp, idx, nwr, ndone, done_cyc, last_hs, last_evt, iter, ref_cyc;
        bit stop, acc, exp_err, prev_pend;

        data = new[nbeats];
        foreach (data[i]) data[i] = $urandom;
        if (abort_at != 0)   nexp = abort_at;
        else if (WRAP)       nexp = nbeats;
        else                 nexp = (nbeats < size) ? nbeats : size;
        exp_err = !WRAP && (abort_at == 0) && (nbeats > size);
        for (int i = 0; i < nexp; i++) begin
            int slot;
            slot = WRAP ? (i % size) : i;
            ea.push_back(base + 32'(slot * 4));
            ed.push_back(data[i]);
            el.push_back(((slot % BL) == BL - 1) || (i == nbeats - 1));
        end

        @(negedge clk);
        start = 1'b1; base_addr = base; buffer_size = 24'(size);
        @(negedge clk);
        start = 1'b0; base_addr = 32'h0; buffer_size = 24'h0;
        #1;
        checks++;
        if (busy !== 1'b1 || slave_tready !== 1'b1) begin
            errors++;
            $display("FAIL %s start: busy %b tready %b, expected 1 1", name, busy, slave_tready);
        end

        idx = 0; nwr = 0; ndone = 0; done_cyc = -1; last_hs = -1; last_evt = -1;
        iter = 0; stop = 0; prev_pend = 0; pa = 0; pd = 0; pl = 0;
        while (1) begin
            case (rmode)
                0:       mem_wready = 1'b1;
                1:       mem_wready = cyc[0];
                default: mem_wready = 1'($urandom_range(0, 1));
            endcase
            if (poke_start && iter == 3) begin
                start = 1'b1; base_addr = 32'hDEAD_0000; buffer_size = 24'd1;
            end else begin
                start = 1'b0;
            end
            if (!stop && idx < nbeats) begin
                slave_tvalid = ($urandom_range(0, 3) != 0);
                slave_tdata  = data[idx];
                slave_tlast  = (idx == nbeats - 1);
            end else begin
                slave_tvalid = 1'b0;
                slave_tlast  = 1'b0;
            end
            #1;
            acc   = slave_tvalid && slave_tready;
            abort = (abort_at != 0) && acc && (idx == abort_at - 1);
            if (acc || abort) last_evt = cyc;

            if (prev_pend) begin
                checks++;
                if (mem_wvalid !== 1'b1 || mem_addr !== pa || mem_wdata !== pd || mem_wlast !== pl) begin
                    errors++;
                    $display("FAIL %s hold: valid %b addr %h data %h last %b, expected 1 %h %h %b",
                             name, mem_wvalid, mem_addr, mem_wdata, mem_wlast, pa, pd, pl);
                end
            end
            if (mem_wvalid && mem_wready) begin
                nwr++; last_hs = cyc;
                checks++;
                if (ea.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra write %0d: addr %h data %h, expected none", name, nwr, mem_addr, mem_wdata);
                end else begin
                    xa = ea.pop_front(); xd = ed.pop_front(); xl = el.pop_front();
                    if (mem_addr !== xa || mem_wdata !== xd || mem_wlast !== xl) begin
                        errors++;
                        $display("FAIL %s write %0d: addr %h data %h last %b, expected %h %h %b",
                                 name, nwr, mem_addr, mem_wdata, mem_wlast, xa, xd, xl);
                    end
                end
            end
            if (chk_stall && mem_wvalid && !mem_wready) begin
                checks++;
                if (slave_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s stall: tready %b with full register, expected 0", name, slave_tready);
                end
            end
            prev_pend = mem_wvalid && !mem_wready;
            pa = mem_addr; pd = mem_wdata; pl = mem_wlast;
            if (done) begin
                ndone++; done_cyc = cyc;
            end
            if (ndone > 0 && !busy) begin
                checks++;
                if (cyc != done_cyc + 1) begin
                    errors++;
                    $display("FAIL %s busy_fall: cycle %0d, expected %0d", name, cyc, done_cyc + 1);
                end
                break;
            end
            if (iter > 3000) begin
                checks++; errors++;
                $display("FAIL %s timeout: no completion after %0d cycles, expected done", name, iter);
                break;
            end
            iter++;
            @(posedge clk);
            if (acc) idx++;
            if (abort) stop = 1;
            @(negedge clk);
            abort = 1'b0;
        end
        slave_tvalid = 1'b0; slave_tlast = 1'b0; abort = 1'b0; start = 1'b0;

        ref_cyc = (last_hs > last_evt) ? last_hs : last_evt;
        checks++;
        if (ndone != 1 || done_cyc != ref_cyc + 2) begin
            errors++;
            $display("FAIL %s done: pulses %0d at cycle %0d, expected 1 at %0d", name, ndone, done_cyc, ref_cyc + 2);
        end
        checks++;
        if (nwr != nexp || ea.size() != 0) begin
            errors++;
            $display("FAIL %s write_count: %0d, expected %0d", name, nwr, nexp);
        end
        checks++;
        if (words_written !== 24'(nexp)) begin
            errors++;
            $display("FAIL %s words_written: %0d, expected %0d", name, words_written, nexp);
        end
        checks++;
        if (error !== exp_err || aborted !== (abort_at != 0)) begin
            errors++;
            $display("FAIL %s status: error %b aborted %b, expected %b %b", name, error, aborted, exp_err, abort_at != 0);
        end
        checks++;
        if (idx != ((abort_at != 0) ? abort_at : nbeats)) begin
            errors++;
            $display("FAIL %s beats_taken: %0d, expected %0d", name, idx, (abort_at != 0) ? abort_at : nbeats);
        end
        $display("xfer %s: base %h size %0d beats %0d writes %0d words %0d error %b aborted %b",
                 name, base, size, nbeats, nwr, words_written, error, aborted);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({slave_tready, busy, done, error, aborted, mem_wvalid, mem_wlast} !== 7'b0) begin
            errors++;
            $display("FAIL reset flags: %b, expected 0000000",
                     {slave_tready, busy, done, error, aborted, mem_wvalid, mem_wlast});
        end
        checks++;
        if (words_written !== 24'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset values: words %h addr %h data %h, expected 0 0 0", words_written, mem_addr, mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        $display("reset: flags and values checked");
    endtask

    task automatic test_basic();
        run_xfer("basic", 32'h0000_1000, 128, 40, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_ready_toggle();
        run_xfer("toggle", 32'h0000_1000, 128, 40, 1, 0, 1'b1, 1'b1);
    endtask

    task automatic test_overflow();
        run_xfer("overflow", 32'h0000_2000, 8, 12, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        run_xfer("abort", 32'h0000_3000, 128, 20, 0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_zero_size();
        bit any_write;
        any_write = 0;
        mem_wready = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_4000; buffer_size = 24'd0;
        @(negedge clk);
        start = 1'b0;
        #1;
        any_write = any_write | mem_wvalid;
        checks++;
        if (busy !== 1'b1 || error !== 1'b1 || done !== 1'b0 || slave_tready !== 1'b0) begin
            errors++;
            $display("FAIL zero N+1: busy %b error %b done %b tready %b, expected 1 1 0 0", busy, error, done, slave_tready);
        end
        @(negedge clk);
        #1;
        any_write = any_write | mem_wvalid;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL zero done: done %b at N+2, expected 1", done);
        end
        @(negedge clk);
        #1;
        any_write = any_write | mem_wvalid;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b1 || words_written !== 24'h0 || any_write) begin
            errors++;
            $display("FAIL zero end: done %b busy %b error %b words %0d wrote %b, expected 0 0 1 0 0",
                     done, busy, error, words_written, any_write);
        end
        $display("zero: error %b words %0d", error, words_written);
    endtask

    task automatic test_reset_midburst();
        mem_wready = 1'b0;
        @(negedge clk);
        start = 1'b1; base_addr = 32'h0000_5000; buffer_size = 24'd64;
        @(negedge clk);
        start = 1'b0;
        slave_tvalid = 1'b1; slave_tdata = 32'hA5A5_0001; slave_tlast = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (mem_wvalid !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset pre: valid %b busy %b, expected 1 1", mem_wvalid, busy);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if ({slave_tready, busy, done, error, aborted, mem_wvalid, mem_wlast} !== 7'b0 ||
            words_written !== 24'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL midreset values: flags %b words %h addr %h data %h, expected all 0",
                     {slave_tready, busy, done, error, aborted, mem_wvalid, mem_wlast},
                     words_written, mem_addr, mem_wdata);
        end
        slave_tvalid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        $display("midreset: outputs cleared asynchronously");
        run_xfer("after_reset", 32'h0000_6000, 32, 20, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            logic [31:0] b;
            b = (i == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
            run_xfer("random", b, $urandom_range(1, 40), $urandom_range(1, 50), 2, 0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        slave_tdata = 32'h0; slave_tvalid = 1'b0; slave_tlast = 1'b0;
        base_addr = 32'h0; buffer_size = 24'h0; mem_wready = 1'b0;
        test_reset();
        test_basic();
        test_ready_toggle();
        test_overflow();
        test_abort();
        test_zero_size();
        test_reset_midburst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
